// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the 1-to-2 byte stream demux.
//   DATA_W      byte width of every stream
//   CH1 / CH2   in_select encodings for the two downstream channels
//   IDLE_DATA   value shown on an empty channel's data output
//   chan_state_e  per-channel occupancy state (EMPTY -> PARTIAL -> FULL)
package demux_pkg;

  localparam int DATA_W = 8;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  localparam logic [DATA_W-1:0] IDLE_DATA = 8'h00;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } chan_state_e;

  // Occupancy-to-state mapping shared by every channel FIFO.
  function automatic chan_state_e occ_to_state(input int occ, input int depth);
    chan_state_e st;
    if (occ == 0) begin
      st = ST_EMPTY;
    end else if (occ >= depth) begin
      st = ST_FULL;
    end else begin
      st = ST_PARTIAL;
    end
    return st;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: synchronous FIFO for one demux output channel.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   push, din   write din when not full
//   pop         remove head entry when not empty
//   dout        head entry, IDLE_DATA when empty
//   full, empty occupancy flags, both derived from the registered state
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  chan_state_e       state_q, state_d;
  logic              push_ok;
  logic              pop_ok;

  // Next-state: guard push/pop by the registered state, then update pointers and occupancy.
  always_comb begin
    push_ok  = push & (state_q != ST_FULL);
    pop_ok   = pop & (state_q != ST_EMPTY);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Push+pop together leaves occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
      2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
      default: occ_d = occ_q;
    endcase
    state_d = occ_to_state(int'(occ_d), DEPTH);
  end

  // State registers: occupancy FSM, pointers and storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= IDLE_DATA;
      end
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Head byte: forced to IDLE_DATA when nothing is buffered so stale bytes never show.
  always_comb begin
    if (state_q == ST_EMPTY) begin
      dout = IDLE_DATA;
    end else begin
      dout = mem_q[rd_ptr_q];
    end
  end

  assign full  = (state_q == ST_FULL);
  assign empty = (state_q == ST_EMPTY);

endmodule

// File: rtl/demux8bit_1to2_stream.sv
// demux8bit_1to2_stream: registered 1-to-2 byte demultiplexer with valid/ready.
// Each byte is steered by in_select (CH1/CH2) into a per-channel FIFO, so a
// stalled channel never blocks traffic for the other one.
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   in_data/in_select/in_valid/in_ready   upstream stream and per-byte route
//   out1_data/out1_valid/out1_ready  channel 1 stream
//   out2_data/out2_valid/out2_ready  channel 2 stream
//   out1_count/out2_count            accepted-push counters (only with DEMUX_STATS_EN)
// Optional feature macro: DEMUX_STATS_EN (adds CNT_WIDTH-bit wrapping push counters).
module demux8bit_1to2_stream
  import demux_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef DEMUX_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_select,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out2_data,
  output logic              out2_valid,
  input  logic              out2_ready
`ifdef DEMUX_STATS_EN
  , output logic [CNT_WIDTH-1:0] out1_count
  , output logic [CNT_WIDTH-1:0] out2_count
`endif
);

  logic full1, full2;
  logic empty1, empty2;
  logic push1, push2;
  logic pop1, pop2;

  // Select decode: ready only looks at the selected channel's registered full flag.
  always_comb begin
    if (in_select == CH2) begin
      in_ready = ~reset & ~full2;
    end else begin
      in_ready = ~reset & ~full1;
    end
    push1 = in_valid & in_ready & (in_select == CH1);
    push2 = in_valid & in_ready & (in_select == CH2);
    pop1  = out1_ready & ~empty1;
    pop2  = out2_ready & ~empty2;
  end

  demux_chan_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .din   (in_data),
    .dout  (out1_data),
    .full  (full1),
    .empty (empty1)
  );

  demux_chan_fifo #(.DEPTH(DEPTH)) u_fifo2 (
    .clk   (clk),
    .reset (reset),
    .push  (push2),
    .pop   (pop2),
    .din   (in_data),
    .dout  (out2_data),
    .full  (full2),
    .empty (empty2)
  );

  assign out1_valid = ~empty1;
  assign out2_valid = ~empty2;

`ifdef DEMUX_STATS_EN
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic [CNT_WIDTH-1:0] cnt2_q, cnt2_d;

  // Counter next-state: +1 per accepted push, natural wrap at all-ones.
  always_comb begin
    if (push1) begin
      cnt1_d = cnt1_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt1_d = cnt1_q;
    end
    if (push2) begin
      cnt2_d = cnt2_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt2_d = cnt2_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign out1_count = cnt1_q;
  assign out2_count = cnt2_q;
`endif

endmodule

// File: tb/tb_demux8bit_1to2_stream.sv
module tb_demux8bit_1to2_stream;

  localparam int DEPTH = 2;
`ifdef DEMUX_STATS_EN
  localparam int CW = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_select = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out1_data, out2_data;
  logic       out1_valid, out2_valid;
  logic       out1_ready = 1'b0;
  logic       out2_ready = 1'b0;
`ifdef DEMUX_STATS_EN
  logic [CW-1:0] out1_count, out2_count;
`endif

  always #5 clk = ~clk;

  demux8bit_1to2_stream #(
    .DEPTH(DEPTH)
`ifdef DEMUX_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
`ifdef DEMUX_STATS_EN
    , .out1_count (out1_count)
    , .out2_count (out2_count)
`endif
  );

  // Reference model: one byte queue per channel plus push counters.
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int unsigned c1 = 0;
  int unsigned c2 = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, compare DUT against the model,
  // then advance the model across the rising edge.
  task automatic step(input logic rst, input logic v, input logic sel,
                      input logic [7:0] d, input logic r1, input logic r2);
    logic exp_rdy;
    int   occ_sel;
    @(negedge clk);
    reset = rst; in_valid = v; in_select = sel; in_data = d;
    out1_ready = r1; out2_ready = r2;
    #1;
    occ_sel = sel ? q2.size() : q1.size();
    exp_rdy = !rst && (occ_sel < DEPTH);
    chk("in_ready",   {31'd0, in_ready},   {31'd0, exp_rdy});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, (q1.size() > 0)});
    chk("out2_valid", {31'd0, out2_valid}, {31'd0, (q2.size() > 0)});
    chk("out1_data",  {24'd0, out1_data},  {24'd0, (q1.size() > 0) ? q1[0] : 8'h00});
    chk("out2_data",  {24'd0, out2_data},  {24'd0, (q2.size() > 0) ? q2[0] : 8'h00});
`ifdef DEMUX_STATS_EN
    chk("out1_count", 32'(out1_count), c1);
    chk("out2_count", 32'(out2_count), c2);
`endif
    @(posedge clk);
    if (rst) begin
      q1.delete(); q2.delete(); c1 = 0; c2 = 0;
    end else begin
      if (r1 && q1.size() > 0) void'(q1.pop_front());
      if (r2 && q2.size() > 0) void'(q2.pop_front());
      if (v && exp_rdy) begin
        if (sel) begin q2.push_back(d); c2 = c2 + 1; end
        else     begin q1.push_back(d); c1 = c1 + 1; end
      end
`ifdef DEMUX_STATS_EN
      c1 = c1 % (1 << CW);
      c2 = c2 % (1 << CW);
`endif
    end
    #1;
  endtask

  initial begin
    // Settle the DUT into a known state before model comparisons begin.
    reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;

    // 1. Reset held with in_valid high.
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("t1_in_ready",   {31'd0, in_ready},   32'd0);
    chk("t1_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("t1_out2_valid", {31'd0, out2_valid}, 32'd0);
    chk("t1_out1_data",  {24'd0, out1_data},  32'h00);
    chk("t1_out2_data",  {24'd0, out2_data},  32'h00);

    // 2. Routing with both consumers ready.
    step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1);
    chk("t2_out1_valid", {31'd0, out1_valid}, 32'd1);
    chk("t2_out1_data",  {24'd0, out1_data},  32'hAA);
    step(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("t2_out1_gone",  {31'd0, out1_valid}, 32'd0);
    chk("t2_out2_valid", {31'd0, out2_valid}, 32'd1);
    chk("t2_out2_data",  {24'd0, out2_data},  32'h55);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("t2_out2_gone",  {31'd0, out2_valid}, 32'd0);

    // 3. Backpressure isolation on channel 1.
    step(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    chk("t3_rdy_sel0",   {31'd0, in_ready},   32'd0);
    chk("t3_out1_head",  {24'd0, out1_data},  32'h01);
    step(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    chk("t3_rdy_sel1",   {31'd0, in_ready},   32'd1);
    chk("t3_out2_data",  {24'd0, out2_data},  32'h03);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_drain_02",   {24'd0, out1_data},  32'h02);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("t3_drained",    {31'd0, out1_valid}, 32'd0);
    chk("t3_ch2_popped", {31'd0, out2_valid}, 32'd0);

    // 4. Concurrent push and pop on channel 1.
    step(1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0);
    chk("t4_valid",      {31'd0, out1_valid}, 32'd1);
    chk("t4_data",       {24'd0, out1_data},  32'h10);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_occ_was_1",  {31'd0, out1_valid}, 32'd0);

    // 5. Reset with both channels full.
    step(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_v1", {31'd0, out1_valid}, 32'd0);
    chk("t5_v2", {31'd0, out2_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_d1", {24'd0, out1_data}, 32'h00);
    chk("t5_d2", {24'd0, out2_data}, 32'h00);
`ifdef DEMUX_STATS_EN
    chk("t5_c1", 32'(out1_count), 32'd0);
    chk("t5_c2", 32'(out2_count), 32'd0);

    // 6. Counter wrap on channel 2.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
    end
    chk("t6_c2_wrap", 32'(out2_count), 32'd1);
    chk("t6_c1_zero", 32'(out1_count), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
